// File: rtl/vc_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vc_allocator_pkg
//  Brief    : NoC router parameter set shared by the VC allocator slice
//             (port/VC counts, index widths, output-port type).
//  Revision : 1.0 - initial release
// ============================================================================
package vc_allocator_pkg;

   localparam int PORT_NUM  = 5;
   localparam int VC_NUM    = 2;
   localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
   localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   typedef logic [PORT_SIZE-1:0] port_t;

endpackage
`default_nettype wire

// File: rtl/vc_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module   : vc_allocator_if
//  Brief    : Request/grant/release bundle between the input buffers, the
//             switch side and the VC allocator.
//  Revision : 1.0 - initial release
// ============================================================================
interface vc_allocator_if #(
   parameter int PORT_NUM = vc_allocator_pkg::PORT_NUM,
   parameter int VC_NUM   = vc_allocator_pkg::VC_NUM
);
   import vc_allocator_pkg::*;

   logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
   port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]              release_i;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o;
   logic                                          error_o;

   // Buffer/switch side
   modport master (
      output request_i, out_port_i, release_i,
      input  vc_valid_o, vc_new_o, error_o
   );

   // Allocator side
   modport slave (
      input  request_i, out_port_i, release_i,
      output vc_valid_o, vc_new_o, error_o
   );

endinterface
`default_nettype wire

// File: rtl/vc_allocator_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : round_robin_arbiter
//  Brief    : N-way round-robin arbiter; grants the first request at or after
//             the pointer and moves the pointer past the winner on update.
//  Revision : 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
   parameter int N = 10
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [N-1:0] request_i,
   output logic      [N-1:0] grant_o,
   input  wire logic         update_i
);
   import vc_allocator_pkg::*;

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] win_idx;
   logic             found;

   // Cyclic scan from the pointer; the first active request wins
   always_comb begin
      int idx;
      grant_o = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && request_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            win_idx      = PTR_W'(idx);
         end
      end
   end

   // Pointer moves one past the winner only when the grant is consumed
   always_comb begin
      ptr_d = ptr_q;
      if (update_i && found) begin
         ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + PTR_W'(1);
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vc_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : vc_allocator
//  Brief    : Separable virtual-channel allocator. One round-robin arbiter per
//             output port picks a requester; the winner receives the lowest
//             free downstream VC of that port. Release pulses free VCs again.
//  Revision : 1.0 - initial release
// ============================================================================
module vc_allocator #(
   parameter int PORT_NUM = vc_allocator_pkg::PORT_NUM,
   parameter int VC_NUM   = vc_allocator_pkg::VC_NUM
) (
   input  wire logic     clk,
   input  wire logic     rst,
   vc_allocator_if.slave bus
);
   import vc_allocator_pkg::*;

   localparam int REQ_NUM = PORT_NUM * VC_NUM;

   logic [PORT_NUM-1:0][VC_NUM-1:0]  avail_q;
   logic [PORT_NUM-1:0][VC_NUM-1:0]  avail_d;
   logic                             error_q;
   logic                             error_d;
   logic [PORT_NUM-1:0][REQ_NUM-1:0] cand;
   logic [PORT_NUM-1:0][REQ_NUM-1:0] grant;
   logic [PORT_NUM-1:0]              port_granted;
   logic [PORT_NUM-1:0][VC_SIZE-1:0] free_vc;

   // Candidates per output port; a port with no free VC offers nothing to
   // its arbiter so the pointer stays put while requesters wait
   always_comb begin
      cand = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               cand[o][p*VC_NUM+v] = bus.request_i[p][v] &&
                                     (bus.out_port_i[p][v] == port_t'(o)) &&
                                     (|avail_q[o]);
            end
         end
      end
   end

   // Lowest-index free downstream VC of every output port
   always_comb begin
      free_vc = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int k = VC_NUM - 1; k >= 0; k--) begin
            if (avail_q[o][k]) begin
               free_vc[o] = VC_SIZE'(k);
            end
         end
      end
   end

   generate
      for (genvar o = 0; o < PORT_NUM; o++) begin : g_port_arb
         assign port_granted[o] = |grant[o];

         round_robin_arbiter #(
            .N (REQ_NUM)
         ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (cand[o]),
            .grant_o   (grant[o]),
            .update_i  (port_granted[o])
         );
      end
   endgenerate

   // Fan the per-port grants back out to the requesting input VCs
   always_comb begin
      bus.vc_valid_o = '0;
      bus.vc_new_o   = '0;
      if (!rst) begin
         for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
               for (int v = 0; v < VC_NUM; v++) begin
                  if (grant[o][p*VC_NUM+v]) begin
                     bus.vc_valid_o[p][v] = 1'b1;
                     bus.vc_new_o[p][v]   = free_vc[o];
                  end
               end
            end
         end
      end
   end

   // Availability: grants consume a VC, releases free one; releasing an
   // already-free VC is flagged but leaves it free
   always_comb begin
      avail_d = avail_q;
      for (int o = 0; o < PORT_NUM; o++) begin
         if (port_granted[o]) begin
            avail_d[o][free_vc[o]] = 1'b0;
         end
      end
      avail_d = avail_d | bus.release_i;
      error_d = |(bus.release_i & avail_q);
   end

   // State registers; reset frees every downstream VC
   always_ff @(posedge clk) begin
      if (rst) begin
         avail_q <= '1;
         error_q <= 1'b0;
      end else begin
         avail_q <= avail_d;
         error_q <= error_d;
      end
   end

   assign bus.error_o = error_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vc_allocator
//  Brief    : Self-checking bench for vc_allocator: directed scenarios plus
//             randomized traffic against a behavioural allocation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vc_allocator;
   import vc_allocator_pkg::*;

   localparam int P = PORT_NUM;
   localparam int V = VC_NUM;
   localparam int N = P * V;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vc_allocator_if #(.PORT_NUM(P), .VC_NUM(V)) bus ();

   vc_allocator #(
      .PORT_NUM (P),
      .VC_NUM   (V)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus for the current cycle
   bit req [P][V];
   int op  [P][V];
   bit rel [P][V];

   // Reference model: free VCs per port, round-robin position, error flag
   bit m_avail [P][V];
   int m_ptr   [P];
   bit m_err;

   // Last sampled DUT outputs
   logic [N-1:0]         obs_valid;
   logic [N*VC_SIZE-1:0] obs_new;
   logic                 obs_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int p = 0; p < P; p++) begin
         for (int v = 0; v < V; v++) begin
            req[p][v] = 1'b0;
            op[p][v]  = 0;
            rel[p][v] = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < P; o++) begin
         m_ptr[o] = 0;
         for (int k = 0; k < V; k++) m_avail[o][k] = 1'b1;
      end
      m_err = 1'b0;
   endtask

   // One clock cycle: drive, compare against the model, advance the model
   task automatic step(input bit r);
      logic [N-1:0]         e_valid;
      logic [N*VC_SIZE-1:0] e_new;
      int win  [P];
      int kfree[P];
      int idx;
      rst = r;
      for (int p = 0; p < P; p++) begin
         for (int v = 0; v < V; v++) begin
            bus.request_i[p][v]  = req[p][v];
            bus.out_port_i[p][v] = port_t'(op[p][v]);
            bus.release_i[p][v]  = rel[p][v];
         end
      end
      #3;
      e_valid = '0;
      e_new   = '0;
      for (int o = 0; o < P; o++) begin
         win[o]   = -1;
         kfree[o] = -1;
         for (int k = V - 1; k >= 0; k--) begin
            if (m_avail[o][k]) kfree[o] = k;
         end
         if (!r && kfree[o] >= 0) begin
            for (int i = 0; i < N; i++) begin
               idx = (m_ptr[o] + i) % N;
               if (win[o] < 0 && req[idx / V][idx % V] && op[idx / V][idx % V] == o) win[o] = idx;
            end
         end
         if (win[o] >= 0) begin
            e_valid[win[o]] = 1'b1;
            e_new[win[o]*VC_SIZE +: VC_SIZE] = VC_SIZE'(kfree[o]);
         end
      end
      obs_valid = bus.vc_valid_o;
      obs_new   = bus.vc_new_o;
      obs_err   = bus.error_o;
      check("vc_valid", 32'(obs_valid), 32'(e_valid));
      check("vc_new", 32'(obs_new), 32'(e_new));
      check("error", 32'(obs_err), 32'(m_err));
      if (r) begin
         model_reset();
      end else begin
         m_err = 1'b0;
         for (int o = 0; o < P; o++) begin
            for (int k = 0; k < V; k++) begin
               if (rel[o][k] && m_avail[o][k]) m_err = 1'b1;
            end
         end
         for (int o = 0; o < P; o++) begin
            if (win[o] >= 0) begin
               m_avail[o][kfree[o]] = 1'b0;
               m_ptr[o] = (win[o] + 1) % N;
            end
         end
         for (int o = 0; o < P; o++) begin
            for (int k = 0; k < V; k++) begin
               if (rel[o][k]) m_avail[o][k] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] new_of(input int p, input int v);
      return 32'(obs_new[(p*V+v)*VC_SIZE +: VC_SIZE]);
   endfunction

   initial begin
      clear_inputs();
      for (int p = 0; p < P; p++) begin
         for (int v = 0; v < V; v++) begin
            bus.request_i[p][v]  = 1'b0;
            bus.out_port_i[p][v] = '0;
            bus.release_i[p][v]  = 1'b0;
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();

      // Reset state
      step(1'b1);
      check("reset_valid", 32'(obs_valid), 32'd0);
      check("reset_error", 32'(obs_err), 32'd0);

      // Single request, zero latency, then nothing once dropped
      req[0][0] = 1'b1; op[0][0] = 1;
      step(1'b0);
      check("single_valid", 32'(obs_valid[0]), 32'd1);
      check("single_new", new_of(0, 0), 32'd0);
      clear_inputs();
      step(1'b0);
      check("single_drop", 32'(obs_valid), 32'd0);

      // Three requesters on port 2, both VCs exhausted, then one release
      req[0][0] = 1'b1; op[0][0] = 2;
      req[2][1] = 1'b1; op[2][1] = 2;
      req[3][0] = 1'b1; op[3][0] = 2;
      step(1'b0);
      check("p2_c1_valid", 32'(obs_valid), 32'h001);
      check("p2_c1_new", new_of(0, 0), 32'd0);
      step(1'b0);
      check("p2_c2_valid", 32'(obs_valid), 32'h020);
      check("p2_c2_new", new_of(2, 1), 32'd1);
      rel[2][0] = 1'b1;
      step(1'b0);
      check("p2_c3_busy", 32'(obs_valid), 32'd0);
      rel[2][0] = 1'b0;
      step(1'b0);
      check("p2_c4_valid", 32'(obs_valid), 32'h040);
      check("p2_c4_new", new_of(3, 0), 32'd0);
      clear_inputs();
      step(1'b0);

      // Independent ports in the same cycle
      req[1][0] = 1'b1; op[1][0] = 4;
      req[4][1] = 1'b1; op[4][1] = 3;
      step(1'b0);
      check("indep_valid", 32'(obs_valid), 32'h204);
      check("indep_new_a", new_of(1, 0), 32'd0);
      check("indep_new_b", new_of(4, 1), 32'd0);
      clear_inputs();

      // Illegal release of an already-free VC
      step(1'b1);
      rel[0][1] = 1'b1;
      step(1'b0);
      clear_inputs();
      req[0][0] = 1'b1; op[0][0] = 0;
      step(1'b0);
      check("err_pulse", 32'(obs_err), 32'd1);
      check("err_grant_new", new_of(0, 0), 32'd0);
      clear_inputs();
      step(1'b0);
      check("err_clear", 32'(obs_err), 32'd0);

      // Exhaust port 1, reset, next request gets VC0
      req[0][0] = 1'b1; op[0][0] = 1;
      step(1'b0);
      clear_inputs();
      req[0][1] = 1'b1; op[0][1] = 1;
      step(1'b0);
      check("exh_second_new", new_of(0, 1), 32'd1);
      clear_inputs();
      req[1][0] = 1'b1; op[1][0] = 1;
      step(1'b1);
      check("rst_valid_low", 32'(obs_valid), 32'd0);
      step(1'b0);
      check("post_rst_valid", 32'(obs_valid[2]), 32'd1);
      check("post_rst_new", new_of(1, 0), 32'd0);
      clear_inputs();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
               req[p][v] = ($urandom_range(0, 99) < 40);
               op[p][v]  = int'($urandom_range(0, P - 1));
               rel[p][v] = m_avail[p][v] ? ($urandom_range(0, 99) < 3)
                                         : ($urandom_range(0, 99) < 30);
            end
         end
         step($urandom_range(0, 199) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
